usart_rx: RTL and testbench
===========================

Name: usart_rx

Overview:
- Asynchronous serial receiver; the downstream neighbour of the USART transmitter, consuming the same frame format.
- Frame format: idle-high line, one start bit (0), DATA_BIT data bits LSB-first, one stop bit (1).
- Bit period is CLK_FREQ/BAUD_RATE clocks, identical to the transmitter, so a Tx/Rx pair built with the same parameters interoperates.
- Delivers each received byte to the fabric as a one-cycle valid pulse, with a held data register and error flags.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division); must be >= 4.
- DATA_BIT, 8, data bits per frame, 5..8. Unused upper bits of data are 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  serial line, asynchronous to clk, idle high.
- data  out  8  last correctly framed byte, held until the next good frame.
- valid  out  1  one-cycle pulse: data updated this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Input sync: rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s. Both sync flops reset to 1.
- Reset values: data=0, valid=0, frame_err=0, busy=0, state=IDLE, bit and clock counters 0.
- Counters: clk_cnt width $clog2(CLKS_PER_BIT)+1, wraps at CLKS_PER_BIT-1. bit_cnt width 4.
- IDLE:
  - rx_s==0 moves to START with clk_cnt=0.
- START:
  - At clk_cnt==CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
  - 1: glitch, return to IDLE with no output.
  - 0: go to DATA with clk_cnt=0, bit_cnt=0.
- DATA:
  - Each time clk_cnt reaches CLKS_PER_BIT-1, shift rx_s into shift register position bit_cnt (LSB first) and increment bit_cnt.
  - After DATA_BIT samples, go to STOP.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1 (mid stop bit), sample rx_s.
  - 1: data<=shift register, valid=1 for exactly one cycle, go to IDLE.
  - 0: frame_err=1 for exactly one cycle, data unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1 (break/line-low recovery), then IDLE.
  - Prevents a held-low line from being decoded as repeated 0x00 frames.
- Latency: valid asserts 2 + CLKS_PER_BIT/2 + (DATA_BIT+1)*CLKS_PER_BIT clocks after the first clk edge seeing rx==0 (±1 clock, due to sync capture).
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit of margin to catch the next start edge; no idle time between frames is required.
- valid and frame_err are never high in the same cycle; neither is ever high for two consecutive cycles.
- No flow control: the consumer must take data within one frame time. A new good frame overwrites data.
- reset mid-frame: the next cycle is IDLE with all outputs at reset values. No partial byte is emitted. Sync flops reload 1, so a line that is low at release is treated as a start edge only after the sync reflects 0.

Optional Feature:
- Macro: USART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected between the last data bit and the stop bit. Extra state PARITY samples it at mid-bit.
  - Adds output parity_err (1 bit, reset 0). It pulses one cycle at the stop-bit decision when the received parity mismatches even parity over the data bits.
  - On mismatch, data is not updated and valid stays 0.
  - If the stop bit is also 0, frame_err takes precedence and parity_err stays 0.
- Undefined:
  - No parity bit, no parity_err port; frame = 1+DATA_BIT+1 bits, matching the transmitter.

Test Plan (CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16; DATA_BIT=8):
- Reset, then drive frame 0xA5 at 16 clk/bit -> exactly one valid pulse, data==8'hA5, frame_err never 1, busy low after the pulse.
- Frames 0x00, 0xFF, 0x3C driven back-to-back with zero idle bits -> three valid pulses, data sequence 00,FF,3C.
- rx low for 5 clocks, then high -> busy pulses high, returns to IDLE, no valid, no frame_err.
- Frame 0x55 with stop bit driven 0, then rx held low 40 clocks, then high -> one frame_err pulse, data unchanged; next good frame 0x12 gives valid with data==8'h12.
- Assert reset during data bit 4 of a frame -> outputs at reset values next cycle; a following clean 0x81 frame is received correctly.
- Parity build (USART_RX_PARITY_EN): 0x07 with parity bit 1 -> valid, data==07. 0x07 with parity bit 0 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/usart_rx.sv
// USART receiver: 2-flop synchronised rx, mid-bit sampling, one-cycle valid/frame_err pulses.
// Optional even-parity bit and parity_err output when USART_RX_PARITY_EN is defined.
module usart_rx #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BIT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
`ifdef USART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef USART_RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
`ifdef USART_RX_PARITY_EN
  logic             r_perr;
  logic             r_par_bit;
`endif
  logic             w_rx_s;

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef USART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef USART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          if (!w_rx_s) r_state <= START;
        end
        START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_state   <= DATA;
              r_bit_cnt <= '0;
              r_shift   <= '0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt                 <= '0;
            r_shift[r_bit_cnt[2:0]]   <= w_rx_s;
            r_bit_cnt                 <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == LAST_DATA) begin
`ifdef USART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`ifdef USART_RX_PARITY_EN
        PARITY: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_par_bit <= w_rx_s;
            r_state   <= STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_ferr  <= 1'b1;
              r_state <= WAIT_HIGH;
            end else begin
              r_state <= IDLE;
`ifdef USART_RX_PARITY_EN
              // Unused upper shift bits are cleared, so a full-width XOR is the data parity.
              if ((^r_shift) != r_par_bit) begin
                r_perr <= 1'b1;
              end else begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
              end
`else
              r_valid <= 1'b1;
              r_data  <= r_shift;
`endif
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        WAIT_HIGH: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
`ifdef USART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx at 16 clocks per bit; parity steps run when USART_RX_PARITY_EN is defined.
module tb_usart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
`ifdef USART_RX_PARITY_EN
  logic       parity_err;
`endif
  logic       busy;

  int n_cmp = 0;
  int n_mis = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_viol = 0;
  logic [7:0] q_data[$];
  logic prev_v = 1'b0;
  logic prev_f = 1'b0;
  logic prev_p = 1'b0;
  logic cur_p;

  usart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef USART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

`ifdef USART_RX_PARITY_EN
  assign cur_p = parity_err;
`else
  assign cur_p = 1'b0;
`endif

  // Pulse monitor: counts outputs and flags overlapping or stretched pulses.
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      q_data.push_back(data);
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (cur_p) n_perr <= n_perr + 1;
    if ((valid && frame_err) || (valid && cur_p) || (frame_err && cur_p) ||
        (valid && prev_v) || (frame_err && prev_f) || (cur_p && prev_p))
      n_viol <= n_viol + 1;
    prev_v <= valid;
    prev_f <= frame_err;
    prev_p <= cur_p;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef USART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_b);
  endtask

`ifdef USART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic p);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
  endtask
`endif

  initial begin
    int v0;
    int f0;
    int q0;
    logic [7:0] d_c3;

    reset = 1'b1;
    rx    = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // Single frame
    v0 = n_valid; f0 = n_ferr; q0 = q_data.size();
    send_frame(8'hA5, 1'b1);
    tick(4);
    check("a5_count", n_valid - v0, 1);
    check("a5_pulse_data", q_data[q0], 8'hA5);
    check("a5_data", data, 8'hA5);
    check("a5_ferr", n_ferr - f0, 0);
    check("a5_busy", busy, 1'b0);

    // Back-to-back frames, no idle between
    v0 = n_valid; q0 = q_data.size();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    tick(4);
    check("b2b_count", n_valid - v0, 3);
    check("b2b_d0", q_data[q0], 8'h00);
    check("b2b_d1", q_data[q0+1], 8'hFF);
    check("b2b_d2", q_data[q0+2], 8'h3C);

    // Short low glitch
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    tick(4);
    check("glitch_busy_hi", busy, 1'b1);
    tick(1);
    rx = 1'b1;
    tick(20);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);

    // Stop bit 0 followed by held-low line
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h55, 1'b0);
    tick(40);
    check("ferr_wait_busy", busy, 1'b1);
    rx = 1'b1;
    tick(20);
    check("ferr_count", n_ferr - f0, 1);
    check("ferr_no_valid", n_valid - v0, 0);
    check("ferr_data_held", data, 8'h3C);
    check("ferr_idle", busy, 1'b0);
    v0 = n_valid;
    send_frame(8'h12, 1'b1);
    tick(4);
    check("after_ferr_count", n_valid - v0, 1);
    check("after_ferr_data", data, 8'h12);

    // Reset in the middle of data bit 4
    v0 = n_valid;
    d_c3 = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d_c3[i]);
    rx = d_c3[4];
    tick(8);
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    rx    = 1'b1;
    tick(1);
    check("midrst_data", data, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_ferr", frame_err, 1'b0);
    check("midrst_busy", busy, 1'b0);
    reset = 1'b0;
    tick(32);
    check("midrst_no_partial", n_valid - v0, 0);
    send_frame(8'h81, 1'b1);
    tick(4);
    check("post_rst_count", n_valid - v0, 1);
    check("post_rst_data", data, 8'h81);

`ifdef USART_RX_PARITY_EN
    v0 = n_valid;
    send_frame_par(8'h07, 1'b1);
    tick(4);
    check("par_ok_count", n_valid - v0, 1);
    check("par_ok_data", data, 8'h07);
    check("par_ok_perr", n_perr, 0);
    v0 = n_valid;
    send_frame_par(8'h07, 1'b0);
    tick(4);
    check("par_bad_perr", n_perr, 1);
    check("par_bad_valid", n_valid - v0, 0);
    check("par_bad_data", data, 8'h07);
`endif

    check("pulse_rules", n_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
